// File: rtl/ctrl_unit_pkg.sv
// rtl/ctrl_unit_pkg.sv - state, opcode and pc_ctrl encodings shared by the control unit
package ctrl_unit_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_WB, S_NEXT, S_HALTED, S_ERROR
  } state_t;

  typedef enum logic [1:0] {CLS_ALU, CLS_FLOW, CLS_HALT} instr_class_t;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;
  localparam logic [1:0] PC_REL  = 2'b11;

  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JR   = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef struct packed {
    instr_class_t cls;
    logic [2:0]   alu_func;
    logic         alu_in_sel;
    logic [1:0]   pc_ctrl;
  } decode_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode decode into class, ALU controls and PC action
module ctrl_decode
  import ctrl_unit_pkg::*;
(
  input  logic [3:0] op,
  output decode_t    dec
);

  always_comb begin
    dec = '{cls: CLS_FLOW, alu_func: 3'd0, alu_in_sel: 1'b0, pc_ctrl: PC_INC};
    if (!op[3]) begin
      dec.cls      = CLS_ALU;
      dec.alu_func = op[2:0];
    end else if (op[3:2] == 2'b10) begin
      dec.cls        = CLS_ALU;
      dec.alu_func   = {1'b0, op[1:0]};
      dec.alu_in_sel = 1'b1;
    end else begin
      case (op)
        OP_JMP:  dec.pc_ctrl = PC_LOAD;
        OP_JR:   dec.pc_ctrl = PC_REL;
        OP_NOP:  dec.pc_ctrl = PC_INC;
        OP_HALT: begin
          dec.cls     = CLS_HALT;
          dec.pc_ctrl = PC_HOLD;
        end
        default: dec.pc_ctrl = PC_INC;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_unit.sv
// rtl/ctrl_unit.sv - instruction sequencer driving the data_path control interface
module ctrl_unit
  import ctrl_unit_pkg::*;
#(
  parameter int DWIDTH  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DWIDTH-1:0] instr,
  input  logic              dp_done,
  output logic              dp_en,
  output logic              en_pc_pulse,
  output logic [1:0]        pc_ctrl,
  output logic [7:0]        offset_addr,
  output logic [7:0]        offset,
  output logic [1:0]        rd,
  output logic [1:0]        rs,
  output logic [3:0]        reg_en,
  output logic [2:0]        alu_func,
  output logic              alu_in_sel,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  state_t            state, state_nx;
  logic [DWIDTH-1:0] ir;
  logic [7:0]        cnt;
  logic [3:0]        op_src;
  decode_t           dec;

  // In DECODE the ROM word is not yet in ir, so branch on it directly.
  assign op_src = (state == S_DECODE) ? instr[15:12] : ir[15:12];

  ctrl_decode u_decode (
    .op  (op_src),
    .dec (dec)
  );

  assign offset_addr = ir[7:0];
  assign offset      = ir[7:0];
  assign rd          = ir[11:10];
  assign rs          = ir[9:8];

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        case (dec.cls)
          CLS_ALU:  state_nx = S_EXEC;
          CLS_HALT: state_nx = S_HALTED;
          default:  state_nx = S_NEXT;
        endcase
      end
      S_EXEC:   state_nx = dp_done ? S_WB : S_WAIT;
      S_WAIT: begin
        if (dp_done)                  state_nx = S_WB;
        else if (cnt == 8'(TIMEOUT))  state_nx = S_ERROR;
      end
      S_WB:     state_nx = S_NEXT;
      S_NEXT:   state_nx = S_FETCH;
      S_HALTED: state_nx = S_HALTED;
      S_ERROR:  state_nx = S_ERROR;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from state_nx so each strobe is a clean flop for its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ir          <= '0;
      cnt         <= '0;
      dp_en       <= 1'b0;
      en_pc_pulse <= 1'b0;
      pc_ctrl     <= PC_HOLD;
      reg_en      <= '0;
      alu_func    <= '0;
      alu_in_sel  <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) begin
        ir         <= instr;
        alu_func   <= dec.alu_func;
        alu_in_sel <= dec.alu_in_sel;
      end
      // cnt holds the number of WAIT cycles spent, including the current one.
      if (state_nx == S_WAIT) cnt <= (state == S_WAIT) ? cnt + 8'd1 : 8'd1;
      else                    cnt <= '0;
      dp_en       <= (state_nx == S_EXEC);
      reg_en      <= (state_nx == S_WB) ? (4'b0001 << ir[11:10]) : 4'b0000;
      en_pc_pulse <= (state_nx == S_NEXT);
      pc_ctrl     <= (state_nx == S_NEXT) ? dec.pc_ctrl : PC_HOLD;
      busy        <= !(state_nx inside {S_IDLE, S_HALTED, S_ERROR});
      halted      <= (state_nx == S_HALTED);
      error       <= (state_nx == S_ERROR);
    end
  end

endmodule
